// File: rtl/irq_cond_pkg.sv
// Shared constants, mode encodings and sizing helpers for the interrupt line conditioner.
package irq_cond_pkg;

  localparam int MAX_SYNC_STAGES = 4;

  typedef enum logic {
    IRQ_MODE_LEVEL = 1'b0,
    IRQ_MODE_EDGE  = 1'b1
  } irq_mode_e;

  // A filter of N cycles counts 0..N-1; one spare bit keeps the compare simple.
  function automatic int cnt_width(input int filter);
    if (filter <= 1) begin
      return 1;
    end else begin
      return $clog2(filter) + 1;
    end
  endfunction

endpackage

// File: rtl/irq_line_filter.sv
// One interrupt line: synchroniser chain followed by a debounce filter.
// Produces the accepted level f_o and a one-cycle-early rise indication rise_o.
module irq_line_filter
  import irq_cond_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic irq_async_i,
  output logic f_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_s;

  // Plain shift chain: no logic may sit between synchroniser flops.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_async_i};
  end

  // Synchroniser state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s_s = sync_q[SYNC_STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_bypass
    assign f_o    = s_s;
    assign rise_o = sync_d[SYNC_STAGES-1] & ~s_s;
  end else begin : g_filter
    localparam int             CW       = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          f_q;
    logic          f_d;

    // Accept a new level only after it has differed for FILTER_CYCLES edges in a row.
    always_comb begin
      f_d   = f_q;
      cnt_d = '0;
      if (s_s != f_q) begin
        if (cnt_q == CNT_LAST) begin
          f_d   = s_s;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end

    // Filter state register.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        cnt_q <= '0;
        f_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        f_q   <= f_d;
      end
    end

    assign f_o    = f_q;
    assign rise_o = f_d & ~f_q;
  end

endmodule

// File: rtl/irq_line_conditioner.sv
// Conditions asynchronous interrupt lines: per-line sync/debounce, level or rising-edge
// capture with pending latch, enable masking; all outputs registered for the relay stage.
module irq_line_conditioner
  import irq_cond_pkg::*;
#(
  parameter int NUM_IRQ       = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter     EDGE_MASK     = 2'b00
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_async_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic [NUM_IRQ-1:0] irq_clr_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic               irq_any_o
);

  localparam logic [NUM_IRQ-1:0] EDGE_LINES = NUM_IRQ'(EDGE_MASK);

  if ((SYNC_STAGES < 2) || (SYNC_STAGES > MAX_SYNC_STAGES)) begin : g_bad_sync
    $error("irq_line_conditioner: SYNC_STAGES must be in 2..4");
  end
  if ($bits(EDGE_MASK) != NUM_IRQ) begin : g_bad_mask
    $error("irq_line_conditioner: EDGE_MASK width must equal NUM_IRQ");
  end

  logic [NUM_IRQ-1:0] f_s;
  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_d;
  logic               irq_any_q;
  logic               irq_any_d;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_line_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
      .clock      (clock),
      .reset_n    (reset_n),
      .irq_async_i(irq_async_i[i]),
      .f_o        (f_s[i]),
      .rise_o     (rise_s[i])
    );
  end

  // Pending capture and masking; a rise on the same edge as a clear wins.
  always_comb begin
    pend_d = '0;
    irq_d  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_LINES[i] == IRQ_MODE_EDGE) begin
        pend_d[i] = (pend_q[i] & ~irq_clr_i[i]) | (rise_s[i] & irq_en_i[i]);
        irq_d[i]  = pend_d[i] & irq_en_i[i];
      end else begin
        pend_d[i] = 1'b0;
        irq_d[i]  = f_s[i] & irq_en_i[i];
      end
    end
    irq_any_d = |irq_d;
  end

  // Pending latches and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_q    <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      irq_q     <= irq_d;
      irq_any_q <= irq_any_d;
    end
  end

  assign irq_o     = irq_q;
  assign irq_any_o = irq_any_q;

endmodule

// File: tb/tb_irq_line_conditioner.sv
// Directed bench: line 0 level, line 1 rising-edge; outputs compared as {irq_any_o, irq_o[1], irq_o[0]}.
module tb_irq_line_conditioner;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] irq_async_i;
  logic [1:0] irq_en_i;
  logic [1:0] irq_clr_i;
  logic [1:0] irq_o;
  logic       irq_any_o;

  int total = 0;
  int bad   = 0;

  irq_line_conditioner #(
    .NUM_IRQ      (2),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4),
    .EDGE_MASK    (2'b10)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .irq_async_i(irq_async_i),
    .irq_en_i   (irq_en_i),
    .irq_clr_i  (irq_clr_i),
    .irq_o      (irq_o),
    .irq_any_o  (irq_any_o)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {irq_any_o, irq_o};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    irq_async_i = 2'b00;
    irq_en_i    = 2'b00;
    irq_clr_i   = 2'b00;
    tick(3);
    check("reset", 3'b000);
    reset_n  = 1'b1;
    irq_en_i = 2'b11;
    tick(2);
    check("idle", 3'b000);

    // 1: level latency, rise and fall
    irq_async_i[0] = 1'b1;
    tick(6);
    check("lvl_rise_e6", 3'b000);
    tick(1);
    check("lvl_rise_e7", 3'b101);
    tick(13);
    check("lvl_hold_e20", 3'b101);
    irq_async_i[0] = 1'b0;
    tick(6);
    check("lvl_fall_e26", 3'b101);
    tick(1);
    check("lvl_fall_e27", 3'b000);

    // 2: 3-cycle glitch rejected, 4-cycle pulse passes for exactly 4 cycles
    tick(3);
    irq_async_i[0] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (k == 3) irq_async_i[0] = 1'b0;
      check($sformatf("glitch3_e%0d", k), 3'b000);
    end
    irq_async_i[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 4) irq_async_i[0] = 1'b0;
      check($sformatf("pulse4_e%0d", k), ((k >= 7) && (k <= 10)) ? 3'b101 : 3'b000);
    end

    // 3: edge capture holds after input drops; clear releases it
    irq_async_i[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (k == 10) irq_async_i[1] = 1'b0;
      if ((k == 5) || (k == 6) || (k == 15) || (k == 30)) begin
        check($sformatf("edge_e%0d", k), (k >= 6) ? 3'b110 : 3'b000);
      end
    end
    irq_clr_i[1] = 1'b1;
    tick(1);
    irq_clr_i[1] = 1'b0;
    check("edge_clr_e31", 3'b000);
    tick(3);
    check("edge_clr_hold", 3'b000);

    // 4: clear sampled on the same edge the pending latch sets
    irq_async_i[1] = 1'b1;
    tick(5);
    check("setclr_e5", 3'b000);
    irq_clr_i[1] = 1'b1;
    tick(1);
    irq_clr_i[1] = 1'b0;
    check("setclr_e6", 3'b110);
    tick(1);
    check("setclr_e7", 3'b110);
    irq_async_i[1] = 1'b0;
    tick(10);
    check("setclr_hold", 3'b110);
    irq_clr_i[1] = 1'b1;
    tick(1);
    irq_clr_i[1] = 1'b0;
    check("setclr_cleared", 3'b000);

    // 5a: rise while masked is not latched
    irq_en_i       = 2'b01;
    irq_async_i[1] = 1'b1;
    tick(10);
    check("mask_rise", 3'b000);
    irq_async_i[1] = 1'b0;
    tick(8);
    irq_en_i = 2'b11;
    tick(1);
    check("mask_no_pend", 3'b000);

    // 5b: pending held while masked, reappears on unmask
    irq_async_i[1] = 1'b1;
    tick(6);
    check("pend_set", 3'b110);
    irq_en_i = 2'b01;
    tick(1);
    check("pend_masked", 3'b000);
    tick(3);
    check("pend_masked_hold", 3'b000);
    irq_en_i = 2'b11;
    tick(1);
    check("pend_unmasked", 3'b110);
    irq_async_i[1] = 1'b0;
    irq_clr_i[1]   = 1'b1;
    tick(1);
    irq_clr_i[1] = 1'b0;
    check("pend_cleared", 3'b000);
    tick(8);

    // 5c: enable drop on a level line
    irq_async_i[0] = 1'b1;
    tick(7);
    check("lvl_en_on", 3'b101);
    irq_en_i = 2'b10;
    check("lvl_en_k", 3'b101);
    tick(1);
    check("lvl_en_k1", 3'b000);
    irq_en_i = 2'b11;
    tick(1);
    check("lvl_en_back", 3'b101);
    irq_async_i[0] = 1'b0;
    tick(7);
    check("lvl_en_fall", 3'b000);

    // 6: reset mid-count clears everything and restarts full latency
    irq_async_i[1] = 1'b1;
    tick(7);
    irq_async_i[1] = 1'b0;
    tick(8);
    check("pre_reset_pend", 3'b110);
    irq_async_i[0] = 1'b1;
    tick(3);
    check("pre_reset_e3", 3'b110);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("reset_mid_e4", 3'b000);
    tick(6);
    check("post_reset_e10", 3'b000);
    tick(1);
    check("post_reset_e11", 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
